multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the single shared ALU, register file write port, instruction register and unified memory port through fetch, decode, execute, memory and writeback steps. It drives `ALU_op` into the ALU decoder and `imm_src` into the immediate extender, and it owns the PC write enable.

---
 rtl/controller_pkg.sv | 77 +++++++
 rtl/instr_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// ============================================================================
// Module      : controller_pkg
// Description : Shared types and encodings for the multicycle RV32I control
//               FSM: state enum, opcodes, ALU_op codes, mux selects and
//               immediate formats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controller_pkg;

   // Control FSM states
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE_R = 4'd6,
      S_EXECUTE_I = 4'd7,
      S_UI        = 4'd8,
      S_ALU_WB    = 4'd9,
      S_BEQ       = 4'd10,
      S_JALR      = 4'd11,
      S_JAL       = 4'd12,
      S_TRAP      = 4'd13
   } ctrl_state_t;

   // RV32I major opcodes
   localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OP_STORE  = 7'b0100011;
   localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] C_OP_JAL    = 7'b1101111;
   localparam logic [6:0] C_OP_JALR   = 7'b1100111;
   localparam logic [6:0] C_OP_LUI    = 7'b0110111;
   localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] C_F3_BEQ    = 3'b000;

   // ALU_op codes, shared with the ALU decoder
   localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] C_ALUOP_UI    = 2'b11;

   // Result mux selects
   localparam logic [1:0] C_RES_ALUOUT = 2'b00;
   localparam logic [1:0] C_RES_MEMDAT = 2'b01;
   localparam logic [1:0] C_RES_ALU    = 2'b10;

   // ALU operand A selects
   localparam logic [1:0] C_SRCA_PC    = 2'b00;
   localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
   localparam logic [1:0] C_SRCA_RS1   = 2'b10;

   // ALU operand B selects
   localparam logic [1:0] C_SRCB_RS2  = 2'b00;
   localparam logic [1:0] C_SRCB_IMM  = 2'b01;
   localparam logic [1:0] C_SRCB_FOUR = 2'b10;

   // Memory address selects
   localparam logic C_ADR_PC     = 1'b0;
   localparam logic C_ADR_RESULT = 1'b1;

   // Immediate formats
   localparam logic [2:0] C_IMM_I = 3'b000;
   localparam logic [2:0] C_IMM_S = 3'b001;
   localparam logic [2:0] C_IMM_B = 3'b010;
   localparam logic [2:0] C_IMM_J = 3'b011;
   localparam logic [2:0] C_IMM_U = 3'b100;

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// Module      : instr_decoder
// Description : Combinational opcode to immediate-format map feeding the
//               immediate extender. Opcodes without an immediate give I.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder
   import controller_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [2:0] imm_src_o
);

   // Immediate format from opcode alone, valid in every FSM state
   always_comb begin
      imm_src_o = C_IMM_I;
      case (opcode_i)
         C_OP_LOAD,
         C_OP_ITYPE,
         C_OP_JALR:   imm_src_o = C_IMM_I;
         C_OP_STORE:  imm_src_o = C_IMM_S;
         C_OP_BRANCH: imm_src_o = C_IMM_B;
         C_OP_JAL:    imm_src_o = C_IMM_J;
         C_OP_LUI,
         C_OP_AUIPC:  imm_src_o = C_IMM_U;
         default:     imm_src_o = C_IMM_I;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM of the multicycle RV32I core. Sequences the
//               shared ALU, register file, instruction register and unified
//               memory port through fetch/decode/execute/memory/writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
   import controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ALU_op,
   output logic [2:0] imm_src,
   output logic       reg_write,
   output logic       retire,
   output logic       illegal
);

   ctrl_state_t state_q;
   ctrl_state_t state_d;
   ctrl_state_t out_state;
   logic        pc_update;
   logic        branch;

   instr_decoder u_instr_decoder (
      .opcode_i  (opcode),
      .imm_src_o (imm_src)
   );

   // State register; reset always returns to FETCH, including out of TRAP
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               C_OP_LOAD,
               C_OP_STORE:  state_d = S_MEM_ADR;
               C_OP_RTYPE:  state_d = S_EXECUTE_R;
               C_OP_ITYPE:  state_d = S_EXECUTE_I;
               C_OP_BRANCH: state_d = (funct3 == C_F3_BEQ) ? S_BEQ : S_TRAP;
               C_OP_JAL:    state_d = S_JAL;
               C_OP_JALR:   state_d = S_JALR;
               C_OP_LUI,
               C_OP_AUIPC:  state_d = S_UI;
               default:     state_d = S_TRAP;
            endcase
         end
         S_MEM_ADR:   state_d = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE_R: state_d = S_ALU_WB;
         S_EXECUTE_I: state_d = S_ALU_WB;
         S_UI:        state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BEQ:       state_d = S_FETCH;
         S_JALR:      state_d = S_JAL;
         S_JAL:       state_d = S_ALU_WB;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_TRAP;
      endcase
   end

   // While reset is high the outputs present FETCH decode with the PC and
   // IR load enables held off, so nothing is committed during reset
   assign out_state = reset ? S_FETCH : state_q;

   // Moore output decode; mem_ready only qualifies the memory-completion pulses
   always_comb begin
      adr_src    = C_ADR_PC;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = C_RES_ALUOUT;
      alu_src_a  = C_SRCA_PC;
      alu_src_b  = C_SRCB_RS2;
      ALU_op     = C_ALUOP_ADD;
      reg_write  = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      case (out_state)
         S_FETCH: begin
            // PC + 4 goes straight to the PC while the instruction is latched
            adr_src    = C_ADR_PC;
            alu_src_a  = C_SRCA_PC;
            alu_src_b  = C_SRCB_FOUR;
            ALU_op     = C_ALUOP_ADD;
            result_src = C_RES_ALU;
            ir_write   = mem_ready & ~reset;
            pc_update  = mem_ready & ~reset;
         end
         S_DECODE: begin
            // Precompute old_pc + imm as the branch/JAL target
            alu_src_a = C_SRCA_OLDPC;
            alu_src_b = C_SRCB_IMM;
            ALU_op    = C_ALUOP_ADD;
         end
         S_MEM_ADR: begin
            alu_src_a = C_SRCA_RS1;
            alu_src_b = C_SRCB_IMM;
            ALU_op    = C_ALUOP_ADD;
         end
         S_MEM_READ: begin
            adr_src    = C_ADR_RESULT;
            result_src = C_RES_ALUOUT;
         end
         S_MEM_WB: begin
            result_src = C_RES_MEMDAT;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         S_MEM_WRITE: begin
            adr_src    = C_ADR_RESULT;
            result_src = C_RES_ALUOUT;
            mem_write  = 1'b1;
            retire     = mem_ready;
         end
         S_EXECUTE_R: begin
            alu_src_a = C_SRCA_RS1;
            alu_src_b = C_SRCB_RS2;
            ALU_op    = C_ALUOP_FUNCT;
         end
         S_EXECUTE_I: begin
            alu_src_a = C_SRCA_RS1;
            alu_src_b = C_SRCB_IMM;
            ALU_op    = C_ALUOP_FUNCT;
         end
         S_UI: begin
            // ALU decoder picks lui vs auipc from opcode[5]
            alu_src_a = C_SRCA_OLDPC;
            alu_src_b = C_SRCB_IMM;
            ALU_op    = C_ALUOP_UI;
         end
         S_ALU_WB: begin
            result_src = C_RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         S_BEQ: begin
            // Subtract for the zero flag; target already sits in alu_out
            alu_src_a  = C_SRCA_RS1;
            alu_src_b  = C_SRCB_RS2;
            ALU_op     = C_ALUOP_SUB;
            result_src = C_RES_ALUOUT;
            branch     = 1'b1;
            retire     = 1'b1;
         end
         S_JALR: begin
            // Replace the decode-time target with rs1 + imm
            alu_src_a = C_SRCA_RS1;
            alu_src_b = C_SRCB_IMM;
            ALU_op    = C_ALUOP_ADD;
         end
         S_JAL: begin
            // PC loads the target from alu_out while ALU forms the link value
            alu_src_a  = C_SRCA_OLDPC;
            alu_src_b  = C_SRCB_FOUR;
            ALU_op     = C_ALUOP_ADD;
            result_src = C_RES_ALUOUT;
            pc_update  = 1'b1;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            illegal = 1'b0;
         end
      endcase
   end

   assign pc_write = pc_update | (branch & zero);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Each
//               instruction is expanded into its expected per-step control
//               pattern, then driven with random memory waits and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] ALU_op;
   logic [2:0] imm_src;
   logic       reg_write;
   logic       retire;
   logic       illegal;

   int n_checks = 0;
   int n_fail   = 0;
   int zforce   = -1;   // -1: random zero flag, else forced value

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct3     (funct3),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .result_src (result_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ALU_op     (ALU_op),
      .imm_src    (imm_src),
      .reg_write  (reg_write),
      .retire     (retire),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // One step of an instruction's control pattern. 'mem' marks a step that
   // waits on memory; its ir_write, pc_update and retire need mem_ready.
   typedef struct packed {
      logic       mem;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       pcu;
      logic       br;
      logic       rw;
      logic       ret;
      logic       ill;
      logic [1:0] rs;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] op;
   } step_t;

   function automatic step_t mk(logic mem, logic adr, logic mw, logic irw, logic pcu,
                                logic br, logic rw, logic ret, logic ill,
                                logic [1:0] rs, logic [1:0] a, logic [1:0] b, logic [1:0] op);
      step_t s;
      s = '{mem, adr, mw, irw, pcu, br, rw, ret, ill, rs, a, b, op};
      return s;
   endfunction

   function automatic logic [2:0] imm_of(logic [6:0] opc);
      case (opc)
         7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
         7'b0100011: return 3'b001;
         7'b1100011: return 3'b010;
         7'b1101111: return 3'b011;
         7'b0110111, 7'b0010111: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [17:0] expect_vec(step_t s, logic mr, logic z, logic [6:0] opc);
      logic q;
      logic pcw;
      q   = s.mem ? mr : 1'b1;
      pcw = (s.pcu & q) | (s.br & z);
      return {pcw, s.adr, s.mw, s.irw & q, s.rs, s.a, s.b, s.op,
              imm_of(opc), s.rw, s.ret & q, s.ill};
   endfunction

   function automatic logic [17:0] observed();
      return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, ALU_op, imm_src, reg_write, retire, illegal};
   endfunction

   // Drive one cycle of a step, compare all outputs, advance a clock
   task automatic do_cycle(string tag, step_t s, logic mr);
      logic [17:0] exp_v;
      logic [17:0] obs_v;
      mem_ready = mr;
      zero      = (zforce < 0) ? 1'($urandom_range(0, 1)) : 1'(zforce);
      #2;
      exp_v = expect_vec(s, mem_ready, zero, opcode);
      obs_v = observed();
      n_checks++;
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s t=%0t obs=%b exp=%b (pcw,adr,mw,irw,rs,a,b,op,imm,rw,ret,ill)",
                tag, $time, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
   endtask

   // Hold reset for n cycles; PC/IR enables, retire and illegal must stay low
   task automatic do_reset(int n);
      logic [3:0] obs_r;
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         zero      = 1'($urandom_range(0, 1));
         #2;
         obs_r = {pc_write, ir_write, retire, illegal};
         n_checks++;
         assert (obs_r === 4'b0000) else begin
            n_fail++;
            $error("FAIL reset_outputs t=%0t obs=%b exp=0000 (pcw,irw,ret,ill)", $time, obs_r);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   // Expand one instruction into its step list and run it. wf/wm are the
   // wait cycles for the fetch and the data access; abort resets the core
   // one wait cycle into the data access.
   task automatic run_instr(string name, logic [6:0] opc, logic [2:0] f3,
                            int wf, int wm, bit abort);
      step_t seq[$];
      step_t fetch_s, dec_s, madr_s, aluwb_s, jal_s;
      int    nmem;
      int    w;
      fetch_s = mk(1, 0,0,1,1,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
      dec_s   = mk(0, 0,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00);
      madr_s  = mk(0, 0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
      aluwb_s = mk(0, 0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00);
      jal_s   = mk(0, 0,0,0,1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00);
      opcode = opc;
      funct3 = f3;
      seq.push_back(fetch_s);
      seq.push_back(dec_s);
      case (opc)
         7'b0000011: begin
            seq.push_back(madr_s);
            seq.push_back(mk(1, 1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00));
            seq.push_back(mk(0, 0,0,0,0,0,1,1,0, 2'b01, 2'b00, 2'b00, 2'b00));
         end
         7'b0100011: begin
            seq.push_back(madr_s);
            seq.push_back(mk(1, 1,1,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00));
         end
         7'b0110011: begin
            seq.push_back(mk(0, 0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10));
            seq.push_back(aluwb_s);
         end
         7'b0010011: begin
            seq.push_back(mk(0, 0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10));
            seq.push_back(aluwb_s);
         end
         7'b0110111, 7'b0010111: begin
            seq.push_back(mk(0, 0,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b11));
            seq.push_back(aluwb_s);
         end
         7'b1101111: begin
            seq.push_back(jal_s);
            seq.push_back(aluwb_s);
         end
         7'b1100111: begin
            seq.push_back(mk(0, 0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00));
            seq.push_back(jal_s);
            seq.push_back(aluwb_s);
         end
         7'b1100011: begin
            if (f3 == 3'b000)
               seq.push_back(mk(0, 0,0,0,0,1,0,1,0, 2'b00, 2'b10, 2'b00, 2'b01));
            else
               seq.push_back(mk(0, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00));
         end
         default:
            seq.push_back(mk(0, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00));
      endcase
      nmem = 0;
      foreach (seq[k]) begin
         if (seq[k].mem) begin
            w = (nmem == 0) ? wf : wm;
            nmem++;
            for (int i = 0; i < w; i++) begin
               if (abort && nmem == 2 && i == 1) begin
                  do_reset(1);
                  return;
               end
               do_cycle($sformatf("%s step%0d wait%0d", name, k, i), seq[k], 1'b0);
            end
            do_cycle($sformatf("%s step%0d done", name, k), seq[k], 1'b1);
         end else if (seq[k].ill) begin
            // TRAP is sticky whatever the inputs do
            for (int i = 0; i < 4; i++) begin
               opcode = 7'($urandom);
               do_cycle($sformatf("%s trap%0d", name, i), seq[k], 1'($urandom_range(0, 1)));
            end
            do_reset(2);
            return;
         end else begin
            do_cycle($sformatf("%s step%0d", name, k), seq[k], 1'($urandom_range(0, 1)));
         end
      end
   endtask

   logic [6:0] legal_ops [10];
   logic [6:0] r_opc;
   logic [2:0] r_f3;

   initial begin
      legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011};
      reset     = 1'b1;
      opcode    = 7'b0110011;
      funct3    = 3'b000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset(2);

      // Directed sequences
      run_instr("rtype", 7'b0110011, 3'b000, 0, 0, 0);
      run_instr("lw",    7'b0000011, 3'b010, 0, 3, 0);
      run_instr("sw",    7'b0100011, 3'b010, 1, 2, 0);
      zforce = 1;
      run_instr("beq_taken", 7'b1100011, 3'b000, 0, 0, 0);
      zforce = 0;
      run_instr("beq_not",   7'b1100011, 3'b000, 0, 0, 0);
      zforce = -1;
      run_instr("bne_trap", 7'b1100011, 3'b001, 0, 0, 0);
      run_instr("jalr",     7'b1100111, 3'b000, 2, 0, 0);
      run_instr("sw_abort", 7'b0100011, 3'b010, 0, 3, 1);
      run_instr("lui",      7'b0110111, 3'b000, 0, 0, 0);
      run_instr("auipc",    7'b0010111, 3'b000, 0, 0, 0);
      run_instr("jal",      7'b1101111, 3'b000, 0, 0, 0);
      run_instr("addi",     7'b0010011, 3'b000, 0, 0, 0);

      // Randomized instruction stream
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0)
            r_opc = 7'($urandom);
         else
            r_opc = legal_ops[$urandom_range(0, 9)];
         r_f3 = ($urandom_range(0, 2) != 0) ? 3'b000 : 3'($urandom_range(0, 7));
         run_instr($sformatf("rnd%0d_op%b_f%0d", n, r_opc, r_f3), r_opc, r_f3,
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
